imem_dmem_port_arbiter: RTL
===========================

Name: imem_dmem_port_arbiter

Overview:
Shares a single-port synchronous word RAM between the core's instruction-fetch port and data port. This lets the pipelined core run from one unified memory. It arbitrates per cycle with data-port priority and a starvation guard for fetch. It routes the 1-cycle-latency read data back to the owner with a valid pulse, and gives the pipeline stall requests plus contention statistics.

Parameters:
ADDR_W, 10, word address width (matches the core's iaddr/daddr).
DATA_W, 32, data width.
MAX_WAIT, 3, consecutive denied fetch cycles before fetch is forced to win; 0 disables the guard (pure data priority).
CNT_W, 16, width of the statistics counters.

Ports:
CLK  in  1  clock, rising edge.
RSTn  in  1  asynchronous, active-low reset.
i_req  in  1  fetch request.
i_addr  in  ADDR_W  fetch word address.
i_gnt  out  1  fetch granted this cycle (combinational).
i_rdata  out  DATA_W  fetch read data (registered, held).
i_valid  out  1  one-cycle pulse: i_rdata updated.
d_rd  in  1  data read request.
d_wr  in  1  data write request.
d_addr  in  ADDR_W  data word address.
d_wdata  in  DATA_W  write data.
d_gnt  out  1  data port granted this cycle (combinational).
d_rdata  out  DATA_W  data read result (registered, held).
d_valid  out  1  one-cycle pulse: d_rdata updated.
stall_if  out  1  i_req & ~i_gnt.
stall_mem  out  1  (d_rd|d_wr) & ~d_gnt.
m_en  out  1  RAM enable.
m_we  out  1  RAM write enable.
m_addr  out  ADDR_W  RAM address.
m_wdata  out  DATA_W  RAM write data.
m_rdata  in  DATA_W  RAM read data, valid the cycle after an enabled read.
err_rw  out  1  sticky: d_rd and d_wr seen high together.
conflict_cnt  out  CNT_W  cycles with i_req and a data request both high.
starve_cnt  out  CNT_W  cycles where the guard forced a fetch grant over a data request.

Behaviour:
- Reset values: all outputs 0. Internal wait counter 0. Response tag = NONE.
- Data request dreq = d_rd | d_wr. If both are high, treat it as a write and set err_rw. err_rw clears only on reset.
- Grant (combinational from current inputs and the wait counter):
  - force = (MAX_WAIT != 0) & i_req & (wait == MAX_WAIT).
  - d_gnt = dreq & ~force.
  - i_gnt = i_req & ~d_gnt.
  - i_gnt and d_gnt are never both high.
- Wait counter:
  - 0 when ~i_req or i_gnt.
  - Otherwise increments, saturating at MAX_WAIT.
  - The forced grant occurs on the cycle the counter equals MAX_WAIT; the counter returns to 0 the next cycle.
- RAM drive:
  - m_en = i_gnt | d_gnt.
  - m_we = d_gnt & d_wr.
  - m_addr = d_addr if d_gnt, else i_addr.
  - m_wdata = d_wdata.
- Response tag (registered each cycle): I if i_gnt; D if d_gnt & ~d_wr; else NONE.
- Read return, the cycle after the grant:
  - Tag I: i_rdata <= m_rdata, i_valid = 1.
  - Tag D: d_rdata <= m_rdata, d_valid = 1.
  - Valids are single-cycle pulses; rdata holds between pulses.
  - Writes produce no valid; a write completes in its grant cycle.
  - Read latency is exactly 1 cycle from grant and back-to-back grants are allowed, giving 1 transaction per cycle.
- Requesters hold address and request until granted; inputs are sampled only in the grant cycle.
- Statistics:
  - conflict_cnt increments when i_req & dreq.
  - starve_cnt increments when force & dreq.
  - Both wrap modulo 2^CNT_W.
- Reset mid-operation: the pending tag is cleared and no valid pulse is issued for a read granted before reset. The wait counter and the statistics clear.

Test Plan:
1. Reset, then i_req=1 at i_addr=5 with RAM[5]=0xDEADBEEF and no data request -> i_gnt=1, m_addr=5, m_we=0; next cycle i_valid=1, i_rdata=0xDEADBEEF; stall_if=0 throughout.
2. Same cycle: i_req at addr 1 and d_rd at addr 2 (RAM[2]=0x11) -> d_gnt=1, i_gnt=0, stall_if=1; next cycle d_valid=1, d_rdata=0x11, fetch granted; conflict_cnt=1.
3. MAX_WAIT=3, i_req and d_rd held high continuously -> data granted 3 cycles, fetch forced on the 4th (stall_mem=1 that cycle), pattern repeats; after 8 cycles starve_cnt=2 and conflict_cnt=8.
4. d_wr at addr 7 with data 0xCAFE, then d_rd at addr 7 -> cycle 1: m_we=1, no d_valid; cycle 2 grants the read; cycle 3: d_valid=1, d_rdata=0xCAFE.
5. d_rd=d_wr=1 at addr 3 -> executes as a write (m_we=1), err_rw=1 and stays 1 after requests drop, until RSTn pulse.
6. Grant a fetch read, assert RSTn=0 before the next edge -> no i_valid after release, all outputs 0, counters 0.

Source files
------------

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data access.
// Data has priority per cycle; a wait counter forces a fetch grant after MAX_WAIT denials.
module imem_dmem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err_rw,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic [CNT_W-1:0]  starve_cnt
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic GUARD_ON = (MAX_WAIT != 0);

    typedef enum logic [1:0] {TAG_NONE, TAG_I, TAG_D} tag_t;

    tag_t              tag;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              dreq;
    logic              force_fetch;

    assign dreq        = d_rd | d_wr;
    assign force_fetch = GUARD_ON & i_req & (wait_cnt == WAIT_MAX);
    assign d_gnt       = dreq & ~force_fetch;
    assign i_gnt       = i_req & ~d_gnt;
    assign stall_if    = i_req & ~i_gnt;
    assign stall_mem   = dreq & ~d_gnt;

    // A simultaneous read+write request is executed as a write.
    assign m_en    = i_gnt | d_gnt;
    assign m_we    = d_gnt & d_wr;
    assign m_addr  = d_gnt ? d_addr : i_addr;
    assign m_wdata = d_wdata;

    // RAM data arrives the cycle after the grant; present it in that cycle and hold it afterwards.
    assign i_valid = (tag == TAG_I);
    assign d_valid = (tag == TAG_D);
    assign i_rdata = i_valid ? m_rdata : i_rdata_q;
    assign d_rdata = d_valid ? m_rdata : d_rdata_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tag          <= TAG_NONE;
            wait_cnt     <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            err_rw       <= 1'b0;
            conflict_cnt <= '0;
            starve_cnt   <= '0;
        end else begin
            if (!i_req || i_gnt)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (i_gnt)
                tag <= TAG_I;
            else if (d_gnt && !d_wr)
                tag <= TAG_D;
            else
                tag <= TAG_NONE;

            if (tag == TAG_I)
                i_rdata_q <= m_rdata;
            if (tag == TAG_D)
                d_rdata_q <= m_rdata;

            if (d_rd && d_wr)
                err_rw <= 1'b1;
            if (i_req && dreq)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            if (force_fetch && dreq)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule
